// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types: default bus widths and the fetch FSM state encoding.
// Pure declarations, no logic or timing.
// Imported by the fetch interface and the fetch stage.
package instr_fetch_pkg;

    localparam int IF_ADDR_W = 3;
    localparam int IF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ROM read port plus decoder valid/ready channel of the fetch stage.
// Wires only, no latency.
// Backpressure is carried by instr_ready against instr_valid.
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int DATA_W = IF_DATA_W
);

    logic              enr;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output enr, pc, instr, instr_pc, instr_valid,
        input  rom_data, instr_ready
    );

    modport slave (
        input  enr, pc, instr, instr_pc, instr_valid,
        output rom_data, instr_ready
    );

endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the combinational ROM, registers the instruction.
// Latency: start -> enr next cycle -> first instr_valid the cycle after; then 1/cycle.
// Backpressure: an unaccepted instr holds PC and IR with enr kept high (stall).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                DATA_W   = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit                WRAP     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt_in,
    output logic              busy,
    instr_fetch_if.master     fb
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              enr_q;
    logic              busy_q;

    logic              accept;
    logic              slot_free;

    assign accept    = valid_q && fb.instr_ready;
    assign slot_free = !valid_q || fb.instr_ready;

    // Priority inside each state: halt, then branch, then capture/stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (halt_in) begin
                    state_d = HALT;
                end else if (br_valid) begin
                    pc_d = br_target;
                end else if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (halt_in) begin
                    state_d = HALT;
                    if (accept) begin
                        valid_d = 1'b0;
                    end
                end else if (br_valid) begin
                    // Redirect flushes whatever is held, accepted or not.
                    pc_d    = br_target;
                    valid_d = 1'b0;
                end else if (slot_free) begin
                    instr_d = fb.rom_data;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    if (!WRAP && (pc_q == {ADDR_W{1'b1}})) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            HALT: begin
                if (accept) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // enr/busy are registered copies of the next state so they stay Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            enr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            enr_q   <= (state_d == FETCH);
            busy_q  <= (state_d == FETCH);
        end
    end

    assign fb.enr         = enr_q;
    assign fb.pc          = pc_q;
    assign fb.instr       = instr_q;
    assign fb.instr_pc    = ipc_q;
    assign fb.instr_valid = valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table on a wrapping instance, a hand sequence
// on a non-wrapping instance, then random traffic against a behavioural model on both.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst, start, br_valid, halt_in, rdy;
    logic [2:0]  br_target;
    logic        busy_w, busy_h;
    logic [15:0] rom [0:7];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(3), .DATA_W(16)) ifw ();
    instr_fetch_if #(.ADDR_W(3), .DATA_W(16)) ifh ();

    assign ifw.rom_data    = ifw.enr ? rom[ifw.pc] : 16'h0000;
    assign ifh.rom_data    = ifh.enr ? rom[ifh.pc] : 16'h0000;
    assign ifw.instr_ready = rdy;
    assign ifh.instr_ready = rdy;

    instr_fetch #(.ADDR_W(3), .DATA_W(16), .RESET_PC(3'd0), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .start(start), .br_valid(br_valid), .br_target(br_target),
        .halt_in(halt_in), .busy(busy_w), .fb(ifw)
    );

    instr_fetch #(.ADDR_W(3), .DATA_W(16), .RESET_PC(3'd0), .WRAP(1'b0)) dut_h (
        .clk(clk), .rst(rst), .start(start), .br_valid(br_valid), .br_target(br_target),
        .halt_in(halt_in), .busy(busy_h), .fb(ifh)
    );

    typedef struct {
        bit         rst, start, rdy, br;
        logic [2:0] tgt;
        bit         halt;
        bit         ev;
        logic [15:0] ei;
        logic [2:0] eipc, epc;
        bit         eenr, full;
    } vec_t;

    typedef struct {
        int mode;   // 0 idle, 1 fetching, 2 halted
        int pc;
        bit iv;
        int instr;
        int ipc;
    } mdl_t;

    vec_t tbl[$];

    function automatic vec_t V(bit r, bit s, bit rd, bit b, logic [2:0] t, bit h,
                               bit ev, logic [15:0] ei, logic [2:0] eipc, logic [2:0] epc,
                               bit eenr, bit full);
        vec_t x;
        x.rst = r; x.start = s; x.rdy = rd; x.br = b; x.tgt = t; x.halt = h;
        x.ev = ev; x.ei = ei; x.eipc = eipc; x.epc = epc; x.eenr = eenr; x.full = full;
        return x;
    endfunction

    // {valid, instr, instr_pc, pc, enr, busy}; instr fields only count when valid or full.
    function automatic logic [24:0] pk(bit v, logic [15:0] i, logic [2:0] ip, logic [2:0] p,
                                       bit e, bit b, bit full);
        logic [15:0] im;
        logic [2:0]  ipm;
        im  = (v || full) ? i  : 16'h0000;
        ipm = (v || full) ? ip : 3'd0;
        return {v, im, ipm, p, e, b};
    endfunction

    task automatic chk(string name, logic [24:0] act, logic [24:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (valid,instr,instr_pc,pc,enr,busy)",
                     name, act, exp);
        end
    endtask

    task automatic drive(bit r, bit s, bit rd, bit b, logic [2:0] t, bit h);
        rst = r; start = s; rdy = rd; br_valid = b; br_target = t; halt_in = h;
    endtask

    function automatic mdl_t mstep(mdl_t m, bit r, bit st, bit rd, bit b, int t, bit h, bit wrap);
        mdl_t n = m;
        if (r) begin
            n.mode = 0; n.pc = 0; n.iv = 0; n.instr = 0; n.ipc = 0;
            return n;
        end
        if (m.mode == 0) begin
            if (h)       n.mode = 2;
            else if (b)  n.pc = t;
            else if (st) n.mode = 1;
        end else if (m.mode == 1) begin
            if (h) begin
                n.mode = 2;
                if (m.iv && rd) n.iv = 0;
            end else if (b) begin
                n.pc = t;
                n.iv = 0;
            end else if (!m.iv || rd) begin
                n.instr = int'(rom[m.pc]);
                n.ipc   = m.pc;
                n.iv    = 1;
                if (!wrap && m.pc == 7) n.mode = 2;
                else                    n.pc = (m.pc + 1) % 8;
            end
        end else if (m.iv && rd) begin
            n.iv = 0;
        end
        return n;
    endfunction

    initial begin
        mdl_t mw, mh;
        for (int i = 0; i < 8; i++) rom[i] = 16'hA000 + 16'(i);
        drive(1, 0, 0, 0, 3'd0, 0);

        //      rst st rdy br tgt halt   ev  instr     ipc   pc   enr full
        tbl.push_back(V(1, 0, 0, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd0, 0, 1));
        tbl.push_back(V(1, 0, 0, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd0, 0, 1));
        tbl.push_back(V(0, 0, 0, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd0, 0, 1));
        tbl.push_back(V(0, 1, 1, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  1, 16'hA000, 3'd0, 3'd1, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  1, 16'hA001, 3'd1, 3'd2, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  1, 16'hA002, 3'd2, 3'd3, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 3'd0, 0,  1, 16'hA002, 3'd2, 3'd3, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 3'd0, 0,  1, 16'hA002, 3'd2, 3'd3, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 3'd0, 0,  1, 16'hA002, 3'd2, 3'd3, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  1, 16'hA003, 3'd3, 3'd4, 1, 0));
        tbl.push_back(V(0, 0, 0, 1, 3'd6, 0,  0, 16'h0000, 3'd0, 3'd6, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  1, 16'hA006, 3'd6, 3'd7, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  1, 16'hA007, 3'd7, 3'd0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  1, 16'hA000, 3'd0, 3'd1, 1, 0));
        tbl.push_back(V(0, 0, 0, 1, 3'd5, 1,  1, 16'hA000, 3'd0, 3'd1, 0, 0));
        tbl.push_back(V(0, 0, 0, 0, 3'd0, 0,  1, 16'hA000, 3'd0, 3'd1, 0, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd1, 0, 0));
        tbl.push_back(V(0, 1, 1, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd1, 0, 0));
        tbl.push_back(V(1, 0, 1, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd0, 0, 1));
        tbl.push_back(V(0, 1, 1, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd0, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  1, 16'hA000, 3'd0, 3'd1, 1, 0));
        tbl.push_back(V(0, 0, 0, 0, 3'd0, 0,  1, 16'hA000, 3'd0, 3'd1, 1, 0));
        tbl.push_back(V(1, 0, 0, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd0, 0, 1));
        tbl.push_back(V(0, 1, 0, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd0, 1, 1));
        tbl.push_back(V(0, 0, 0, 0, 3'd0, 0,  1, 16'hA000, 3'd0, 3'd1, 1, 0));
        tbl.push_back(V(1, 0, 0, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd0, 0, 1));
        tbl.push_back(V(0, 0, 0, 1, 3'd5, 0,  0, 16'h0000, 3'd0, 3'd5, 0, 0));
        tbl.push_back(V(0, 1, 0, 0, 3'd0, 0,  0, 16'h0000, 3'd0, 3'd5, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 0,  1, 16'hA005, 3'd5, 3'd6, 1, 0));
        tbl.push_back(V(0, 0, 1, 0, 3'd0, 1,  0, 16'h0000, 3'd0, 3'd6, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].rdy, tbl[i].br, tbl[i].tgt, tbl[i].halt);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                pk(ifw.instr_valid, ifw.instr, ifw.instr_pc, ifw.pc, ifw.enr, busy_w, tbl[i].full),
                pk(tbl[i].ev, tbl[i].ei, tbl[i].eipc, tbl[i].epc, tbl[i].eenr, tbl[i].eenr,
                   tbl[i].full));
        end

        // Non-wrapping instance: run off the end of the ROM and halt at the last address.
        drive(1, 0, 0, 0, 3'd0, 0);
        @(posedge clk); #1;
        drive(0, 1, 1, 0, 3'd0, 0);
        @(posedge clk); #1;
        chk("nowrap_start", pk(ifh.instr_valid, ifh.instr, ifh.instr_pc, ifh.pc, ifh.enr, busy_h, 1'b0),
            pk(1'b0, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0));
        drive(0, 0, 1, 0, 3'd0, 0);
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            logic [2:0] epc;
            kk  = 3'(k);
            epc = (k < 7) ? 3'(k + 1) : 3'd7;
            @(posedge clk); #1;
            chk($sformatf("nowrap_cap%0d", k),
                pk(ifh.instr_valid, ifh.instr, ifh.instr_pc, ifh.pc, ifh.enr, busy_h, 1'b0),
                pk(1'b1, 16'hA000 + 16'(k), kk, epc, k < 7, k < 7, 1'b0));
        end
        drive(0, 0, 0, 0, 3'd0, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("nowrap_hold", pk(ifh.instr_valid, ifh.instr, ifh.instr_pc, ifh.pc, ifh.enr, busy_h, 1'b0),
                pk(1'b1, 16'hA007, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0));
        end
        drive(0, 1, 0, 1, 3'd2, 1);
        @(posedge clk); #1;
        chk("nowrap_halt_br", pk(ifh.instr_valid, ifh.instr, ifh.instr_pc, ifh.pc, ifh.enr, busy_h, 1'b0),
            pk(1'b1, 16'hA007, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0));
        drive(0, 0, 1, 0, 3'd0, 0);
        @(posedge clk); #1;
        chk("nowrap_drain", pk(ifh.instr_valid, ifh.instr, ifh.instr_pc, ifh.pc, ifh.enr, busy_h, 1'b0),
            pk(1'b0, 16'h0000, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0));

        // Random traffic with fresh ROM contents, both instances against the model.
        for (int i = 0; i < 8; i++) rom[i] = 16'($urandom);
        mw = '{default: 0};
        mh = '{default: 0};
        for (int c = 0; c < 3000; c++) begin
            bit r, s, rd, b, h;
            logic [2:0] t;
            r  = (c == 0) || ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 2) != 0);
            b  = ($urandom_range(0, 7) == 0);
            h  = ($urandom_range(0, 59) == 0);
            t  = 3'($urandom_range(0, 7));
            drive(r, s, rd, b, t, h);
            mw = mstep(mw, r, s, rd, b, int'(t), h, 1'b1);
            mh = mstep(mh, r, s, rd, b, int'(t), h, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("rand_w%0d", c),
                pk(ifw.instr_valid, ifw.instr, ifw.instr_pc, ifw.pc, ifw.enr, busy_w, 1'b0),
                pk(mw.iv, mw.instr[15:0], mw.ipc[2:0], mw.pc[2:0], mw.mode == 1, mw.mode == 1, 1'b0));
            chk($sformatf("rand_h%0d", c),
                pk(ifh.instr_valid, ifh.instr, ifh.instr_pc, ifh.pc, ifh.enr, busy_h, 1'b0),
                pk(mh.iv, mh.instr[15:0], mh.ipc[2:0], mh.pc[2:0], mh.mode == 1, mh.mode == 1, 1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
